// File: rtl/freq_note_decoder.sv
// Nearest-note classifier: linear search over all 64 switch codes for the table
// frequency closest to freq_in. Optional macro NOTE_DIFF_EN builds the diff/in_tune path.
module freq_note_decoder #(
  parameter int FREQ_W = 12,
  parameter int TOL    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [5:0]        sw_out,
  output logic [2:0]        note,
  output logic              accident,
  output logic [1:0]        octave,
  output logic              in_tune,
  output logic [FREQ_W:0]   diff,
  output logic              out_valid,
  input  logic              out_ready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid holds its payload stable until that edge, and ready never waits on valid.
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [5:0]        code_q, code_d;
  logic [FREQ_W-1:0] best_err_q, best_err_d;
  logic [5:0]        best_code_q, best_code_d;
  logic [5:0]        sw_q, sw_d;
  logic              out_valid_q, out_valid_d;

  logic [FREQ_W-1:0]        tf;
  logic signed [FREQ_W:0]   cur_diff;
  logic [FREQ_W-1:0]        cur_err;

  function automatic logic [FREQ_W-1:0] table_freq(input logic [5:0] c);
    logic [FREQ_W-1:0] base;
    base = '0;
    case (c[3:0])
      4'h0: base = FREQ_W'(261);
      4'h1: base = FREQ_W'(293);
      4'h2: base = FREQ_W'(330);
      4'h3: base = FREQ_W'(349);
      4'h4: base = FREQ_W'(392);
      4'h5: base = FREQ_W'(440);
      4'h6: base = FREQ_W'(494);
      4'h7: base = FREQ_W'(522);
      4'h8: base = FREQ_W'(277);
      4'h9: base = FREQ_W'(311);
      4'hA: base = FREQ_W'(330);
      4'hB: base = FREQ_W'(370);
      4'hC: base = FREQ_W'(415);
      4'hD: base = FREQ_W'(466);
      4'hE: base = FREQ_W'(494);
      default: base = FREQ_W'(554);
    endcase
    case (c[5:4])
      2'd0:    table_freq = base;
      2'd1:    table_freq = base << 1;
      2'd2:    table_freq = base << 2;
      default: table_freq = base >> 1;
    endcase
  endfunction

  always_comb begin
    tf       = table_freq(code_q);
    cur_diff = $signed({1'b0, freq_q}) - $signed({1'b0, tf});
    cur_err  = cur_diff[FREQ_W] ? FREQ_W'(-cur_diff) : FREQ_W'(cur_diff);
  end

`ifdef NOTE_DIFF_EN
  logic signed [FREQ_W:0] best_diff_q, best_diff_d;
  logic signed [FREQ_W:0] diff_q, diff_d;
  logic                   in_tune_q, in_tune_d;
`endif

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    code_d      = code_q;
    best_err_d  = best_err_q;
    best_code_d = best_code_q;
    sw_d        = sw_q;
    out_valid_d = out_valid_q;
`ifdef NOTE_DIFF_EN
    best_diff_d = best_diff_q;
    diff_d      = diff_q;
    in_tune_d   = in_tune_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          freq_d      = freq_in;
          code_d      = 6'd0;
          best_err_d  = '1;
          best_code_d = 6'd0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        // Strict compare keeps the earliest (lowest) code on ties.
        if (cur_err < best_err_q) begin
          best_err_d  = cur_err;
          best_code_d = code_q;
`ifdef NOTE_DIFF_EN
          best_diff_d = cur_diff;
`endif
        end
        code_d = code_q + 6'd1;
        if (code_q == 6'd63) state_d = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          sw_d        = best_code_q;
          out_valid_d = 1'b1;
`ifdef NOTE_DIFF_EN
          diff_d      = best_diff_q;
          in_tune_d   = (best_err_q <= FREQ_W'(TOL));
`endif
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      freq_q      <= '0;
      code_q      <= '0;
      best_err_q  <= '1;
      best_code_q <= '0;
      sw_q        <= '0;
      out_valid_q <= 1'b0;
`ifdef NOTE_DIFF_EN
      best_diff_q <= '0;
      diff_q      <= '0;
      in_tune_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      code_q      <= code_d;
      best_err_q  <= best_err_d;
      best_code_q <= best_code_d;
      sw_q        <= sw_d;
      out_valid_q <= out_valid_d;
`ifdef NOTE_DIFF_EN
      best_diff_q <= best_diff_d;
      diff_q      <= diff_d;
      in_tune_q   <= in_tune_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sw_out    = sw_q;
  assign note      = sw_q[2:0];
  assign accident  = sw_q[3];
  assign octave    = sw_q[5:4];
`ifdef NOTE_DIFF_EN
  assign diff      = diff_q;
  assign in_tune   = in_tune_q;
`else
  assign diff      = '0;
  assign in_tune   = 1'b0;
`endif

endmodule

// File: tb/tb_freq_note_decoder.sv
// Directed bench for freq_note_decoder: nearest-note results, latency, back-pressure
// and reset mid-scan. Expectations follow the build (NOTE_DIFF_EN on or off).
module tb_freq_note_decoder;

  logic        clk;
  logic        rst;
  logic [11:0] freq_in;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  sw_out;
  logic [2:0]  note;
  logic        accident;
  logic [1:0]  octave;
  logic        in_tune;
  logic [12:0] diff;
  logic        out_valid;
  logic        out_ready;

`ifdef NOTE_DIFF_EN
  localparam bit DIFF_ON = 1'b1;
`else
  localparam bit DIFF_ON = 1'b0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [5:0] exp_q[$];

  freq_note_decoder #(.FREQ_W(12), .TOL(4)) dut (
    .clk(clk), .rst(rst), .freq_in(freq_in), .in_valid(in_valid), .in_ready(in_ready),
    .sw_out(sw_out), .note(note), .accident(accident), .octave(octave),
    .in_tune(in_tune), .diff(diff), .out_valid(out_valid), .out_ready(out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one input, wait for the result and score it; returns at the sample after the
  // edge that raised out_valid (no handshake yet).
  task automatic run_case(input string tag, input logic [11:0] f, input logic [5:0] e_sw,
                          input int e_diff, input bit e_tune);
    int  lat;
    bit  busy_ok;
    logic [5:0]  e;
    logic [12:0] ed;
    lat = 0;
    while (!in_ready && lat < 200) begin
      tick();
      lat++;
    end
    exp_q.push_back(e_sw);
    freq_in  = f;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    e  = exp_q.pop_front();
    ed = DIFF_ON ? 13'(e_diff) : 13'd0;
    check_eq({tag, "_latency"}, lat, 65);
    check_eq({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check_eq({tag, "_sw"}, {26'd0, sw_out}, {26'd0, e});
    check_eq({tag, "_fields"}, {26'd0, octave, accident, note}, {26'd0, e});
    check_eq({tag, "_diff"}, {19'd0, diff}, {19'd0, ed});
    check_eq({tag, "_tune"}, {31'd0, in_tune}, {31'd0, e_tune & DIFF_ON});
  endtask

  // One edge with out_ready high: out_valid drops, result is held, block is idle.
  task automatic complete(input string tag, input logic [5:0] held_sw);
    out_ready = 1'b1;
    tick();
    check_eq({tag, "_ov_low"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, "_held"}, {26'd0, sw_out}, {26'd0, held_sw});
  endtask

  initial begin
    bit saw_ov;
    rst       = 1'b1;
    freq_in   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_sw", {26'd0, sw_out}, 32'd0);
    check_eq("rst_diff", {19'd0, diff}, 32'd0);
    check_eq("rst_tune", {31'd0, in_tune}, 32'd0);

    run_case("a440", 12'd440, 6'b000101, 0, 1'b1);   complete("a440", 6'b000101);
    run_case("f444", 12'd444, 6'b000101, 4, 1'b1);   complete("f444", 6'b000101);
    run_case("f445", 12'd445, 6'b000101, 5, 1'b0);   complete("f445", 6'b000101);

    // reset at T+30 discards the scan
    freq_in  = 12'd2000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_sw", {26'd0, sw_out}, 32'd0);
    check_eq("mid_rst_diff", {19'd0, diff}, 32'd0);
    saw_ov = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) saw_ov = 1'b1;
      tick();
    end
    check_eq("mid_rst_no_result", {31'd0, saw_ov}, 32'd0);

    run_case("f269", 12'd269, 6'b000000, 8, 1'b0);      complete("f269", 6'b000000);
    run_case("f522", 12'd522, 6'b000111, 0, 1'b1);      complete("f522", 6'b000111);
    run_case("f0", 12'd0, 6'b110000, -130, 1'b0);       complete("f0", 6'b110000);
    run_case("f4095", 12'd4095, 6'b101111, 1879, 1'b0); complete("f4095", 6'b101111);
    run_case("f330", 12'd330, 6'b000010, 0, 1'b1);      complete("f330", 6'b000010);
    run_case("f443", 12'd443, 6'b000101, 3, 1'b1);      complete("f443", 6'b000101);

    // back-pressure: result held, extra in_valid ignored
    out_ready = 1'b0;
    run_case("bp2000", 12'd2000, 6'b100110, 24, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        freq_in  = 12'd440;
        in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      tick();
      check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_hold_sw", {26'd0, sw_out}, {26'd0, 6'b100110});
    end
    check_eq("bp_hold_diff", {19'd0, diff}, {19'd0, (DIFF_ON ? 13'd24 : 13'd0)});
    complete("bp2000", 6'b100110);
    tick();
    check_eq("bp_no_second", {31'd0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
